// File: rtl/alu_issue_stage.sv
// Command issue stage for a 32-bit combinational ALU: buffers commands, issues one at a time,
// captures the result and flags, and keeps an accumulator so commands can be chained.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_use_acc,
    output logic             alu_enable,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [32:0]      alu_res,
    input  logic             alu_zf,
    input  logic             alu_cf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32:0]      out_res,
    output logic             out_zf,
    output logic             out_cf,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int DATA_W = 32;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              use_acc;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    cmd_t              mem [DEPTH];
    cmd_t              head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] acc;
    state_t            state;
    state_t            state_nxt;
    logic              push;
    logic              pop;
    logic              capture;
    logic              retire;

    assign in_ready = !rst && (count < (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE) || (count != '0);

    // Storage carries no reset: the flushed pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: in_opcode, a: in_a, b: in_b, use_acc: in_use_acc};
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            acc        <= '0;
            cmd_count  <= '0;
            alu_enable <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_zf     <= 1'b0;
            out_cf     <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);

            // Issue: accumulator is resolved here, not when the command was queued.
            if (pop) begin
                alu_enable <= 1'b1;
                alu_opcode <= head.op;
                alu_b      <= head.b;
                alu_a      <= head.use_acc ? acc : head.a;
            end else if (state == IDLE) begin
                alu_enable <= 1'b0;
            end

            // Capture: the ALU has settled on the registered operands.
            if (capture) begin
                out_res    <= alu_res;
                out_zf     <= alu_zf;
                out_cf     <= alu_cf;
                out_valid  <= 1'b1;
                acc        <= alu_res[DATA_W-1:0];
                alu_enable <= 1'b0;
            end

            // Retire on the downstream handshake.
            if (retire) begin
                out_valid <= 1'b0;
                cmd_count <= cmd_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed table, multi-cycle corner sequences and a randomized run
// scored against an in-order command/accumulator model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_use_acc = 1'b0;
    logic        alu_enable;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [32:0] alu_res;
    logic        alu_zf;
    logic        alu_cf;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] out_res;
    logic        out_zf;
    logic        out_cf;
    logic        busy;
    logic [15:0] cmd_count;

    int n_vec = 0;
    int n_err = 0;

    alu_issue_stage #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
        .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_res(alu_res), .alu_zf(alu_zf), .alu_cf(alu_cf),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zf(out_zf), .out_cf(out_cf), .busy(busy), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a} + 33'd1;
            3'd3:    return {1'b0, a} - 33'd1;
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return ~{1'b0, a};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Combinational ALU the stage drives.
    always_comb begin
        alu_res = alu_enable ? ref_alu(alu_opcode, alu_a, alu_b) : 33'd0;
        alu_zf  = (alu_res == 33'd0);
        alu_cf  = alu_res[32];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: commands complete strictly in order, so each expected result is known at push.
    logic [34:0] exp_q[$];
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;
    logic        last_push;

    task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ua, input logic ordy);
        logic [32:0] res;
        logic [34:0] e;
        logic        hs;
        @(negedge clk);
        rst = r; in_valid = v; in_opcode = op; in_a = a; in_b = b; in_use_acc = ua;
        out_ready = ordy;
        #1;
        last_push = 1'b0;
        hs = 1'b0;
        if (r) begin
            exp_q.delete();
            m_acc = '0;
            m_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                hs = 1'b1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_result: got 0x%0h, expected no result", out_res);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_res", 64'(out_res), 64'(e[34:2]));
                    check("sb_flags", {62'd0, out_zf, out_cf}, {62'd0, e[1:0]});
                end
                m_cnt++;
            end
            if (in_valid && in_ready) begin
                last_push = 1'b1;
                res = ref_alu(op, ua ? m_acc : a, b);
                m_acc = res[31:0];
                exp_q.push_back({res, res == 33'd0, res[32]});
            end
        end
        @(posedge clk);
        #1;
        if (hs) check("cmd_count", 64'(cmd_count), 64'(m_cnt[15:0]));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, ordy);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 200) begin
            idle(1'b1);
            k++;
        end
        check(name, {63'd0, busy || (exp_q.size() != 0)}, 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ua;
        logic [32:0] res;
        logic        zf;
        logic        cf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] prev;
        logic [31:0] exp_a;
        logic [32:0] snap_res;
        logic [2:0]  snap_flags;
        int          accepted;
        int          k;
        logic        stable;

        tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'h1,         1'b0, 33'h1_0000_0000, 1'b0, 1'b1};
        tbl[1] = '{3'd1, 32'd5,         32'd5,         1'b0, 33'h0_0000_0000, 1'b1, 1'b0};
        tbl[2] = '{3'd1, 32'd3,         32'd5,         1'b0, 33'h1_FFFF_FFFE, 1'b0, 1'b1};
        tbl[3] = '{3'd0, 32'd10,        32'd20,        1'b0, 33'h0_0000_001E, 1'b0, 1'b0};
        tbl[4] = '{3'd2, 32'd0,         32'd0,         1'b1, 33'h0_0000_001F, 1'b0, 1'b0};
        tbl[5] = '{3'd6, 32'hFFFF_FFFF, 32'h0,         1'b0, 33'h1_0000_0000, 1'b0, 1'b1};
        tbl[6] = '{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 33'h0_F000_F000, 1'b0, 1'b0};
        tbl[7] = '{3'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 33'h0_FFFF_FFFF, 1'b0, 1'b0};
        tbl[8] = '{3'd7, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 33'h0_0000_0000, 1'b1, 1'b0};
        tbl[9] = '{3'd3, 32'h1234_5678, 32'd0,         1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b1};

        step(1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rst_out_valid",  64'(out_valid), 64'd0);
        check("rst_alu_enable", 64'(alu_enable), 64'd0);
        check("rst_out_res",    64'(out_res), 64'd0);
        check("rst_alu_a",      64'(alu_a), 64'd0);
        check("rst_busy",       64'(busy), 64'd0);
        check("rst_cmd_count",  64'(cmd_count), 64'd0);
        idle(1'b1);
        check("rst_in_ready",   64'(in_ready), 64'd1);

        // Directed table: one command at a time from an idle, empty stage.
        prev = '0;
        for (int i = 0; i < 10; i++) begin
            exp_a = tbl[i].ua ? prev : tbl[i].a;
            step(1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua, 1'b1);
            check($sformatf("t%0d_enable_pre", i), 64'(alu_enable), 64'd0);
            idle(1'b1);
            check($sformatf("t%0d_enable", i), 64'(alu_enable), 64'd1);
            check($sformatf("t%0d_alu_a", i), 64'(alu_a), 64'(exp_a));
            check($sformatf("t%0d_alu_b_op", i), {29'd0, alu_opcode, alu_b},
                  {29'd0, tbl[i].op, tbl[i].b});
            idle(1'b1);
            check($sformatf("t%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("t%0d_out_res", i), 64'(out_res), 64'(tbl[i].res));
            check($sformatf("t%0d_flags", i), {62'd0, out_zf, out_cf},
                  {62'd0, tbl[i].zf, tbl[i].cf});
            idle(1'b1);
            check($sformatf("t%0d_retired", i), {62'd0, out_valid, busy}, 64'd0);
            check($sformatf("t%0d_count", i), 64'(cmd_count), 64'(i + 1));
            prev = tbl[i].res[31:0];
        end

        // Backpressure: out_ready low, six commands offered.
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            k = 0;
            last_push = 1'b0;
            while (!last_push && k < 10) begin
                step(1'b0, 1'b1, 3'(i), 32'd100 * 32'(i) + 32'd7, 32'(i + 3), 1'(i % 2), 1'b0);
                k++;
            end
            if (last_push) accepted++;
        end
        check("stall_accepted", 64'(accepted), 64'd5);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        snap_res   = out_res;
        snap_flags = {out_valid, out_zf, out_cf};
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 3'd7, $urandom, $urandom, 1'b0, 1'b0);
            if (out_res !== snap_res || {out_valid, out_zf, out_cf} !== snap_flags) stable = 1'b0;
        end
        check("stall_stable", 64'(stable), 64'd1);
        check("stall_valid", 64'(out_valid), 64'd1);
        k = 0;
        last_push = 1'b0;
        while (!last_push && k < 20) begin
            step(1'b0, 1'b1, 3'd5, 32'h0000_0F00, 32'h0000_00F0, 1'b1, 1'b1);
            k++;
        end
        check("retry_accepted", 64'(last_push), 64'd1);
        drain("stall_drain");

        // Reset while a command executes with two more queued.
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, 32'(i + 1), 32'd1000, 1'b0, 1'b1);
        idle(1'b1);
        check("mid_in_exec", 64'(alu_enable), 64'd1);
        check("mid_queued", 64'(exp_q.size()), 64'd3);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("mid_rst_state", {61'd0, out_valid, busy, alu_enable}, 64'd0);
        idle(1'b1);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            if (out_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        check("mid_no_stale", 64'(stable), 64'd1);
        step(1'b0, 1'b1, 3'd2, 32'd5, 32'd0, 1'b1, 1'b1);
        idle(1'b1);
        check("mid_acc_cleared", 64'(alu_a), 64'd0);
        idle(1'b1);
        check("mid_first_res", 64'(out_res), 64'd1);
        drain("mid_drain");

        // Randomized traffic against the in-order model.
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            step(1'b0, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), ra, rb,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        drain("rand_drain");
        check("rand_count", 64'(cmd_count), 64'(m_cnt[15:0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Upstream command stage for the 32-bit combinational ALU. It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the ALU's enable/a/b/opcode inputs, captures the ALU's 33-bit result and zero/carry flags, and presents them downstream over a valid/ready interface. It also keeps a result accumulator so that commands can be chained.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
CNT_W, 16, width of the completed-command counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  command present
in_ready  output  1  FIFO can accept a command
in_opcode  input  3  ALU opcode: 000 add, 001 sub, 010 inc, 011 dec, 100 and, 101 or, 110 not, 111 xor
in_a  input  32  operand A
in_b  input  32  operand B
in_use_acc  input  1  replace operand A with the accumulator at issue time
alu_enable  output  1  ALU enable (registered)
alu_a  output  32  ALU operand A (registered)
alu_b  output  32  ALU operand B (registered)
alu_opcode  output  3  ALU opcode (registered)
alu_res  input  33  ALU result (combinational from ALU)
alu_zf  input  1  ALU zero flag
alu_cf  input  1  ALU carry flag (equals alu_res[32])
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_res  output  33  captured result
out_zf  output  1  captured zero flag
out_cf  output  1  captured carry flag
busy  output  1  FSM not in IDLE, or FIFO not empty
cmd_count  output  CNT_W  completed handshakes; wraps

Behaviour:
- Reset, while rst=1 at an edge:
  - FIFO flushed: pointers and count set to 0.
  - FSM set to IDLE.
  - Accumulator set to 0; cmd_count set to 0.
  - alu_enable, alu_a, alu_b, alu_opcode set to 0.
  - out_valid, out_res, out_zf, out_cf set to 0.
- in_ready = !rst && (fifo_count < DEPTH). It is combinational from current state only.
- Push: on in_valid && in_ready, {in_opcode, in_a, in_b, in_use_acc} is written at the tail.
- A push while full is ignored. in_ready is low, and a same-cycle pop does not open a slot until the next cycle.
- FIFO push and pop in the same cycle are both honoured; the count is unchanged.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if FIFO not empty, pop the head and register alu_opcode <= op and alu_b <= b. alu_a <= (use_acc ? acc : a). alu_enable <= 1. Go to EXEC. If the FIFO is empty, alu_enable <= 0 and stay in IDLE.
  - EXEC: the ALU settles combinationally during this cycle. At the edge: out_res <= alu_res, out_zf <= alu_zf, out_cf <= alu_cf, out_valid <= 1, acc <= alu_res[31:0], alu_enable <= 0. Go to DONE.
  - DONE: hold all out_* stable while out_valid && !out_ready. On out_ready, at the edge: out_valid <= 0, cmd_count increments (mod 2^CNT_W), go to IDLE.
- alu_a, alu_b and alu_opcode hold their last values when alu_enable=0.
- The stage does not recompute flags. out_zf and out_cf come from the ALU, with zf evaluated over all 33 bits.
- Latency: a push into an empty FIFO with the FSM in IDLE gives alu_enable=1 two edges later and out_valid=1 three edges later.
- Minimum issue interval is 3 cycles per command when out_ready is held at 1.
- Chaining: in_use_acc is resolved at issue, not at push. It uses the accumulator from the most recently completed EXEC.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-operation, in EXEC or DONE: any pending result is discarded, out_valid drops at that edge, and queued commands are lost.
- in_* values are sampled only on a push handshake. Changes while in_ready=0 have no effect.

Test Plan:
1. Reset, then push add a=0xFFFFFFFF, b=0x1 -> alu_enable=1 two cycles later; out_res=0x1_00000000, out_cf=1, out_zf=0, out_valid three cycles after the push; cmd_count=1 after the handshake.
2. Push sub a=5, b=5, then sub a=3, b=5 -> first out_res=0, zf=1, cf=0; second out_res=0x1_FFFFFFFE, cf=1, zf=0.
3. Push add a=10, b=20, then inc with in_use_acc=1 and a=0 -> second issue shows alu_a=30; out_res=31.
4. Hold out_ready=0 and push 6 commands -> in_ready=0 once 4 are queued (one is held in DONE); out_* stays stable while stalled. Release out_ready -> all 5 accepted commands are delivered in order; the 6th command is retried and accepted.
5. Assert rst during EXEC with 2 commands queued -> next cycle out_valid=0, busy=0, in_ready=1, alu_enable=0, acc=0; no stale result emerges afterwards.
6. Push not a=0xFFFFFFFF -> out_res=0x1_00000000, zf=0, cf=1; confirms flags pass through unaltered.
